camdenmil_uart_rx: RTL
======================

# camdenmil_uart_rx

UART receiver with a small output FIFO that feeds command bytes into `tt_um_camdenmil_sky25b` from a dedicated input pin (`ui_in[3]`). It samples 8N1 serial data, checks framing, and buffers received bytes so the core consumes them with a valid/ready handshake rather than strict serial timing. It instantiates directly inside the top, upstream of the command decoder.

## Interface

**Parameters**

- `CLKS_PER_BIT`, default 16: clocks per bit period; even, at least 8.
- `FIFO_DEPTH`, default 4: FIFO entries; power of 2, at least 2.

**Ports**

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain only.
- `ena`  in  1  design-selected enable from the TinyTapeout top.
- `rx`  in  1  raw serial line, asynchronous, idle high.
- `rd_data`  out  8  byte at the FIFO head.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer pops the head when `rd_valid && rd_ready`.
- `frame_err`  out  1  one-cycle pulse when a bad stop bit is seen.
- `overflow`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation

- **Synchroniser:** `rx` passes through a 2-flop synchroniser. The flops reset to 1. The FSM uses only the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** when `rxs`=0 and `ena`=1, go to START and clear the bit-clock counter.
  - **START:** at count CLKS_PER_BIT/2−1 (mid-bit), sample `rxs`.
    - If `rxs`=1, this is a false start: return to IDLE with no pulse.
    - Otherwise go to DATA and reset the counter.
  - **DATA:** sample `rxs` every CLKS_PER_BIT clocks, at the mid-bit phase. Shift LSB-first into an 8-bit register. Go to STOP after the 8th bit.
  - **STOP:** sample `rxs` one bit period later.
    - If `rxs`=1, push the byte and go to IDLE.
    - If `rxs`=0, pulse `frame_err`, discard the byte, and go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rxs`=1 (break condition), then go to IDLE.
- **`ena`=0:** forces the FSM to IDLE on the next clock and aborts any partial byte with no pulse. FIFO contents and the handshake remain operational.
- **FIFO:** circular buffer with read/write pointers of width $clog2(FIFO_DEPTH)+1. `rd_data` is driven from the head register, not a registered read, so it is valid in the same cycle as `rd_valid`.
  - Push while full, with no pop that cycle: drop the byte and pulse `overflow`.
  - Push and pop in the same cycle while full: both happen, no overflow, level unchanged.
  - Push and pop in the same cycle while non-empty: level unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo 2·FIFO_DEPTH.

## Timing

- **Reset values:**
  - FSM in IDLE.
  - `rd_valid`=0, `rd_data`=0, `frame_err`=0, `overflow`=0, `fifo_level`=0.
  - Synchroniser flops at 1.
  - All FIFO storage cleared.
- **Reset mid-frame:** state is cleared immediately (asynchronous reset). After reset releases, the receiver resyncs on the next falling edge only if `rxs` has first returned to 1.
- **Latency:** the stop-bit sample occurs 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT clocks (±1) after the falling edge on `rx`. The push registers on that edge, and `rd_valid`/`fifo_level` update on the following cycle.
- **Pop:** `rd_ready` sampled high with `rd_valid`=1 advances the head at the clock edge. The next byte, or `rd_valid`=0, is visible the following cycle.
- **Pulses:** `frame_err` and `overflow` are high for exactly one clock and are registered.
- **Back-to-back frames:** a new start edge is accepted in the first IDLE cycle after STOP. There is no dead time beyond the sampling phase.

## Structure

- **Package `camdenmil_uart_pkg`:** FSM state enum (`uart_state_t`), the byte width constant (8), and a `clog2`-based level-width helper.
- **Sub-module `camdenmil_sync_fifo`:** parameterised by width and depth. It owns the pointers, full/empty logic, `fifo_level`, and `overflow`.
- **`camdenmil_uart_rx`:** contains the synchroniser, bit counter, FSM, and shift register.

## Test plan

1. **Single byte:** CLKS_PER_BIT=16; send 0xA5 with a valid stop bit, `rd_ready`=0. Expect `rd_valid` to rise 2+8+144 (±1) clocks after the start edge, `rd_data`=0xA5, `fifo_level`=1, no pulses.
2. **False start:** drive `rx` low for 4 clocks, then high. Expect FSM back in IDLE, no push, no `frame_err`.
3. **Framing error:** send 0x3C with a low stop bit held low for 2 bit periods. Expect a single-cycle `frame_err`, FIFO unchanged, then 0x55 is received correctly after `rx` idles.
4. **Overflow:** send 5 bytes 0x01–0x05 with `rd_ready`=0. Expect `fifo_level`=4 and one `overflow` pulse. Popping then yields 0x01, 0x02, 0x03, 0x04, then `rd_valid`=0.
5. **Simultaneous push/pop when full:** hold `rd_ready`=1 exactly on the push cycle of the 5th byte. Expect no overflow, `fifo_level` stays 4, and the head advances to 0x02.
6. **Abort mid-frame:** pulse `rst_n` low mid-byte, and separately drop `ena` mid-byte. Expect all outputs at reset values (for reset), no push, and correct reception of the next full frame.

Source files
------------

// File: rtl/camdenmil_uart_pkg.sv
// Shared types and sizing helpers for the camdenmil UART receive path.
package camdenmil_uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_t;

    // Occupancy counters need one extra bit so "full" is distinct from "empty".
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/camdenmil_sync_fifo.sv
// Small first-word-fall-through FIFO; head entry is visible together with o_rd_valid.
module camdenmil_sync_fifo
    import camdenmil_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_rd_data,
    output logic                        o_rd_valid,
    output logic                        o_overflow,
    output logic [lvl_width(DEPTH)-1:0] o_level
);

    localparam int PW = lvl_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             r_overflow;

    logic [PW-1:0]    w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == PW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[gi] <= '0;
                end else if (w_do_push && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_overflow <= i_push && w_full && !w_do_pop;
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_rd_valid = !w_empty;
    assign o_overflow = r_overflow;
    assign o_level    = w_level;

endmodule

// File: rtl/camdenmil_uart_rx.sv
// 8N1 UART receiver with framing check, feeding a small output FIFO.
module camdenmil_uart_rx
    import camdenmil_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ena,
    input  logic                             rx,
    output logic [BYTE_W-1:0]                rd_data,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic                             frame_err,
    output logic                             overflow,
    output logic [lvl_width(FIFO_DEPTH)-1:0] fifo_level
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic              r_sync1;
    logic              r_sync2;
    logic [1:0]        r_fill;
    logic              r_armed;
    logic              w_armed_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_next;
    logic [BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0] w_shift_next;
    logic              r_frame_err;
    logic              w_frame_err_next;
    logic              w_push;
    logic              w_rxs;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_fill      <= 2'b00;
            r_armed     <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_fill      <= {r_fill[0], 1'b1};
            r_armed     <= w_armed_next;
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // The line must be seen idle (after the synchroniser has refilled) before a start
    // is accepted, so a reset or disable in the middle of a frame cannot fake a start.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt + 1'b1;
        w_bit_next       = r_bit_idx;
        w_shift_next     = r_shift;
        w_frame_err_next = 1'b0;
        w_push           = 1'b0;
        w_armed_next     = r_armed || (w_rxs && r_fill[1]);

        if (!ena) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_bit_next   = '0;
            w_armed_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_next = '0;
                    w_bit_next = '0;
                    if (!w_rxs && r_armed) w_state_next = ST_START;
                end
                ST_START: begin
                    if (r_cnt == HALF_M1) begin
                        w_cnt_next   = '0;
                        w_state_next = w_rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        w_cnt_next   = '0;
                        w_shift_next = {w_rxs, r_shift[BYTE_W-1:1]};
                        w_bit_next   = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        w_cnt_next = '0;
                        if (w_rxs) begin
                            w_push       = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_frame_err_next = 1'b1;
                            w_state_next     = ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    w_cnt_next = '0;
                    if (w_rxs) w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign frame_err = r_frame_err;

    camdenmil_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (rd_ready),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_overflow  (overflow),
        .o_level     (fifo_level)
    );

endmodule
